regfile_access_arbiter: RTL and testbench
=========================================

Name: regfile_access_arbiter

Overview:
- Two-requester arbiter and sequencer in front of the generated register file's write port 0 and read port 0.
- Requester 0 is the host bus bridge; requester 1 is the internal hardware status updater.
- Serialises single-beat read/write transactions with round-robin fairness and returns one response per transaction.
- Parks the register-file read address on an unused address when idle, so read-clean registers are cleared only by genuine reads.

Parameters:
- ADDR_W, 8, register address width.
- DATA_W, 32, data width; must be a multiple of 8.
- BE_W, DATA_W/8, byte-enable width.
- IDLE_ADDR, 8'hFF, parking address driven on rf_rd_addr when no read is in progress; must not map to any register.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- mN_req_valid  in  1  request valid (N = 0, 1).
- mN_req_ready  out  1  request accepted this cycle.
- mN_req_we  in  1  1 = write, 0 = read.
- mN_req_addr  in  ADDR_W  register address.
- mN_req_wdata  in  DATA_W  write data.
- mN_req_be  in  BE_W  byte enables (writes only).
- mN_rsp_valid  out  1  one-cycle response pulse.
- mN_rsp_rdata  out  DATA_W  read data; 0 for writes.
- rf_wr_en  out  1  register-file write enable.
- rf_wr_addr  out  ADDR_W  register-file write address.
- rf_wr_data  out  DATA_W  register-file write data.
- rf_wr_be  out  BE_W  register-file byte enables.
- rf_rd_addr  out  ADDR_W  register-file read address.
- rf_rd_data  in  DATA_W  register-file combinational read data.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset is rst_n, asynchronous, active-low; clock is clk.
- FSM states are IDLE, ACCESS and RESP. Reset values:
  - state = IDLE, last_grant = 1 (so m0 wins the first tie).
  - hold registers = 0, rdata register = 0.
  - All outputs 0, except rf_rd_addr = IDLE_ADDR.
- IDLE:
  - Winner selection: if only one requester is valid, it wins. If both are valid, the one not equal to last_grant wins.
  - The winner's mN_req_ready is combinational (state==IDLE && winner && valid). The loser's ready stays 0.
  - On handshake: capture we/addr/wdata/be and the grant id into hold registers, set last_grant = winner, go to ACCESS.
  - No valid: remain in IDLE.
- ACCESS (exactly 1 cycle):
  - Write: rf_wr_en = 1, with rf_wr_addr/data/be taken from the hold registers.
  - Read: rf_rd_addr = hold_addr, and rf_rd_data is registered into rdata at the end of the cycle.
  - Always go to RESP.
- RESP (exactly 1 cycle):
  - Granted requester gets mN_rsp_valid = 1 with mN_rsp_rdata = rdata (0 for a write). The other requester's rsp signals stay 0.
  - There is no response back-pressure; requesters must accept the pulse.
  - Go to IDLE.
- rf_rd_addr equals IDLE_ADDR in every cycle except ACCESS-with-read. rf_wr_en is 0 outside ACCESS. Each transaction touches the register file for exactly one cycle.
- Timing:
  - Handshake in cycle T, register-file access in T+1, response in T+2.
  - Next handshake possible in T+3, giving a maximum throughput of 1 transaction per 3 cycles.
- Requesters may drop valid without a handshake; nothing is latched unless ready && valid.
- Request fields are sampled only at the handshake; later changes are ignored.
- Write data and byte enables pass through unmodified; the arbiter performs no read-modify-write.
- rsp_rdata holds its last value outside the response pulse; only the rsp_valid pulse is significant.
- Reset asserted mid-transaction:
  - Immediately deasserts rf_wr_en and rsp_valid, and restores rf_rd_addr to IDLE_ADDR.
  - The pending transaction is dropped with no response.
  - After release, m0 wins the first tie.

Test Plan:
- After reset, m0 writes addr 0x04, data 0xDEADBEEF, be 0xF → m0_req_ready high 1 cycle; rf_wr_en high exactly in T+1 with 0x04/0xDEADBEEF/0xF; m0_rsp_valid in T+2 with rdata 0.
- m0 reads 0x04, with the register-file model returning 0x12345678 → rf_rd_addr = 0x04 only in T+1, 0xFF otherwise; m0_rsp_rdata = 0x12345678 in T+2; m1_rsp_valid stays 0.
- m0 and m1 both continuously valid, 4 reads each → grant order m0, m1, m0, m1, …; handshakes exactly 3 cycles apart; no response crosses to the wrong requester.
- m1 writes be 4'b0010, data 0xAABBCCDD → rf_wr_be = 4'b0010 and rf_wr_data = 0xAABBCCDD in ACCESS.
- rst_n asserted during ACCESS of an m1 write → rf_wr_en falls without a clock edge; no m1_rsp_valid; after release, simultaneous requests grant m0 first.
- 100 idle cycles, then m1 asserts valid for 1 cycle while state is busy → rf_rd_addr = 0xFF and rf_wr_en = 0 throughout; the dropped request is never issued.

Source files
------------

// File: rtl/regfile_access_arbiter.sv
// regfile_access_arbiter
// Two-requester round-robin arbiter that serialises single-beat read/write
// transactions onto register-file write port 0 and read port 0. Each
// transaction goes through three phases: handshake (IDLE), a single
// register-file access cycle (ACCESS), and a one-cycle response pulse (RESP).
// When no read is in progress, the read address is parked on IDLE_ADDR. This
// ensures that read-clean registers are cleared only by genuine reads.

module regfile_access_arbiter #(
  parameter int                ADDR_W    = 8,
  parameter int                DATA_W    = 32,
  parameter int                BE_W      = DATA_W / 8,
  parameter logic [ADDR_W-1:0] IDLE_ADDR = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  // requester 0 (host bus bridge)
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic              m0_req_we,
  input  logic [ADDR_W-1:0] m0_req_addr,
  input  logic [DATA_W-1:0] m0_req_wdata,
  input  logic [BE_W-1:0]   m0_req_be,
  output logic              m0_rsp_valid,
  output logic [DATA_W-1:0] m0_rsp_rdata,
  // requester 1 (hardware status updater)
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic              m1_req_we,
  input  logic [ADDR_W-1:0] m1_req_addr,
  input  logic [DATA_W-1:0] m1_req_wdata,
  input  logic [BE_W-1:0]   m1_req_be,
  output logic              m1_rsp_valid,
  output logic [DATA_W-1:0] m1_rsp_rdata,
  // register file side
  output logic              rf_wr_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic [DATA_W-1:0] rf_wr_data,
  output logic [BE_W-1:0]   rf_wr_be,
  output logic [ADDR_W-1:0] rf_rd_addr,
  input  logic [DATA_W-1:0] rf_rd_data,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                r_hold_we;
  logic [ADDR_W-1:0]   r_hold_addr;
  logic [DATA_W-1:0]   r_hold_wdata;
  logic [BE_W-1:0]     r_hold_be;
  logic                r_hold_gnt;
  logic [DATA_W-1:0]   r_m0_rdata;
  logic [DATA_W-1:0]   r_m1_rdata;

  logic                w_any_valid;
  logic                w_winner;
  logic                w_handshake;
  logic                w_acc_read;

  // On a tie, the requester that was not granted last wins; otherwise, the only valid requester wins.
  assign w_any_valid = m0_req_valid | m1_req_valid;
  assign w_winner    = (m0_req_valid & m1_req_valid) ? ~r_last_grant : m1_req_valid;
  assign w_acc_read  = (r_state == ST_ACCESS) & ~r_hold_we;

  // State register; an asynchronous reset drops any in-flight transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic and handshake decode (ready is combinational in IDLE).
  always_comb begin
    w_state_nxt  = r_state;
    m0_req_ready = 1'b0;
    m1_req_ready = 1'b0;
    w_handshake  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any_valid) begin
          w_handshake  = 1'b1;
          m0_req_ready = ~w_winner;
          m1_req_ready = w_winner;
          w_state_nxt  = ST_ACCESS;
        end else begin
          w_state_nxt  = ST_IDLE;
        end
      end
      ST_ACCESS: w_state_nxt = ST_RESP;
      ST_RESP:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Capture the winning request and its grant id at the handshake; later changes to request fields are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_hold_we    <= 1'b0;
      r_hold_addr  <= '0;
      r_hold_wdata <= '0;
      r_hold_be    <= '0;
      r_hold_gnt   <= 1'b0;
    end else if (w_handshake) begin
      r_last_grant <= w_winner;
      r_hold_gnt   <= w_winner;
      r_hold_we    <= w_winner ? m1_req_we    : m0_req_we;
      r_hold_addr  <= w_winner ? m1_req_addr  : m0_req_addr;
      r_hold_wdata <= w_winner ? m1_req_wdata : m0_req_wdata;
      r_hold_be    <= w_winner ? m1_req_be    : m0_req_be;
    end else begin
      r_last_grant <= r_last_grant;
      r_hold_gnt   <= r_hold_gnt;
      r_hold_we    <= r_hold_we;
      r_hold_addr  <= r_hold_addr;
      r_hold_wdata <= r_hold_wdata;
      r_hold_be    <= r_hold_be;
    end
  end

  // Latch the response data for the granted requester during ACCESS (zero for writes); the value holds until its next access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_m0_rdata <= '0;
      r_m1_rdata <= '0;
    end else if (r_state == ST_ACCESS) begin
      if (r_hold_gnt) begin
        r_m1_rdata <= r_hold_we ? '0 : rf_rd_data;
      end else begin
        r_m0_rdata <= r_hold_we ? '0 : rf_rd_data;
      end
    end else begin
      r_m0_rdata <= r_m0_rdata;
      r_m1_rdata <= r_m1_rdata;
    end
  end

  // Outputs are decoded from registers only, so an asynchronous reset clears them immediately.
  assign rf_wr_en     = (r_state == ST_ACCESS) & r_hold_we;
  assign rf_wr_addr   = r_hold_addr;
  assign rf_wr_data   = r_hold_wdata;
  assign rf_wr_be     = r_hold_be;
  assign rf_rd_addr   = w_acc_read ? r_hold_addr : IDLE_ADDR;
  assign m0_rsp_valid = (r_state == ST_RESP) & ~r_hold_gnt;
  assign m1_rsp_valid = (r_state == ST_RESP) & r_hold_gnt;
  assign m0_rsp_rdata = r_m0_rdata;
  assign m1_rsp_rdata = r_m1_rdata;
  assign busy         = (r_state != ST_IDLE);

endmodule

// File: tb/tb_regfile_access_arbiter.sv
// tb_regfile_access_arbiter
// Randomised and directed stimulus. A behavioural model predicts the grant,
// the register-file access, and the response for every handshake. The
// predictions are queued and compared on each falling clock edge.

module tb_regfile_access_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  v;
  logic [1:0]  wev;
  logic [7:0]  ad [2];
  logic [31:0] wd [2];
  logic [3:0]  bev [2];
  logic        m0_req_ready, m1_req_ready, m0_rsp_valid, m1_rsp_valid;
  logic [31:0] m0_rsp_rdata, m1_rsp_rdata;
  logic        rf_wr_en, busy;
  logic [7:0]  rf_wr_addr, rf_rd_addr;
  logic [31:0] rf_wr_data, rf_rd_data;
  logic [3:0]  rf_wr_be;

  int checks = 0;
  int errors = 0;

  regfile_access_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req_valid(v[0]), .m0_req_ready(m0_req_ready), .m0_req_we(wev[0]),
    .m0_req_addr(ad[0]), .m0_req_wdata(wd[0]), .m0_req_be(bev[0]),
    .m0_rsp_valid(m0_rsp_valid), .m0_rsp_rdata(m0_rsp_rdata),
    .m1_req_valid(v[1]), .m1_req_ready(m1_req_ready), .m1_req_we(wev[1]),
    .m1_req_addr(ad[1]), .m1_req_wdata(wd[1]), .m1_req_be(bev[1]),
    .m1_rsp_valid(m1_rsp_valid), .m1_rsp_rdata(m1_rsp_rdata),
    .rf_wr_en(rf_wr_en), .rf_wr_addr(rf_wr_addr), .rf_wr_data(rf_wr_data),
    .rf_wr_be(rf_wr_be), .rf_rd_addr(rf_rd_addr), .rf_rd_data(rf_rd_data),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file stand-in that is driven only by the DUT's write port.
  logic [31:0] rf_mem [256];
  assign rf_rd_data = rf_mem[rf_rd_addr];
  always @(posedge clk) begin
    if (rf_wr_en) begin
      for (int b = 0; b < 4; b++)
        if (rf_wr_be[b]) rf_mem[rf_wr_addr][8*b +: 8] <= rf_wr_data[8*b +: 8];
    end
  end

  // Reference model state.
  logic [31:0] model_mem [256];
  typedef struct { int cyc; int g; logic we; logic [7:0] addr; logic [31:0] data; logic [3:0] be; } acc_t;
  typedef struct { int cyc; int g; logic [31:0] rd; } rsp_t;
  acc_t acc_q[$];
  rsp_t rsp_q[$];
  int   cyc = 0;
  int   cnt = 0;
  bit   last = 1'b1;
  acc_t e;
  rsp_t r;
  bit   e0, e1;
  int   g;

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] new_v, input logic [3:0] be);
    logic [31:0] res;
    res = old_v;
    for (int b = 0; b < 4; b++) if (be[b]) res[8*b +: 8] = new_v[8*b +: 8];
    return res;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, cyc, act, exp);
    end
  endtask

  // Monitor and scoreboard, evaluated on every falling edge.
  initial begin
    for (int i = 0; i < 256; i++) begin
      model_mem[i] = 32'h0101_0101 * i;
      rf_mem[i]    = 32'h0101_0101 * i;
    end
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        acc_q.delete();
        rsp_q.delete();
        cnt  = 0;
        last = 1'b1;
      end else begin
        chk("busy", {31'd0, busy}, {31'd0, cnt != 0});
        if (acc_q.size() > 0 && acc_q[0].cyc == cyc) begin
          e = acc_q.pop_front();
          chk("acc_wr_en", {31'd0, rf_wr_en}, {31'd0, e.we});
          chk("acc_rd_addr", {24'd0, rf_rd_addr}, e.we ? 32'h0000_00FF : {24'd0, e.addr});
          if (e.we) begin
            chk("acc_wr_addr", {24'd0, rf_wr_addr}, {24'd0, e.addr});
            chk("acc_wr_data", rf_wr_data, e.data);
            chk("acc_wr_be", {28'd0, rf_wr_be}, {28'd0, e.be});
            model_mem[e.addr] = merge(model_mem[e.addr], e.data, e.be);
            r.rd = 32'd0;
          end else begin
            r.rd = model_mem[e.addr];
          end
          r.cyc = cyc + 1;
          r.g   = e.g;
          rsp_q.push_back(r);
        end else begin
          chk("idle_wr_en", {31'd0, rf_wr_en}, 32'd0);
          chk("idle_rd_addr", {24'd0, rf_rd_addr}, 32'h0000_00FF);
        end
        if (rsp_q.size() > 0 && rsp_q[0].cyc == cyc) begin
          r = rsp_q.pop_front();
          chk("rsp_valid0", {31'd0, m0_rsp_valid}, {31'd0, r.g == 0});
          chk("rsp_valid1", {31'd0, m1_rsp_valid}, {31'd0, r.g == 1});
          chk("rsp_rdata", (r.g == 1) ? m1_rsp_rdata : m0_rsp_rdata, r.rd);
        end else begin
          chk("no_rsp0", {31'd0, m0_rsp_valid}, 32'd0);
          chk("no_rsp1", {31'd0, m1_rsp_valid}, 32'd0);
        end
        e0 = 1'b0;
        e1 = 1'b0;
        if (cnt == 0) begin
          if (v[0] && (!v[1] || last)) e0 = 1'b1;
          else if (v[1]) e1 = 1'b1;
        end
        chk("ready0", {31'd0, m0_req_ready}, {31'd0, e0});
        chk("ready1", {31'd0, m1_req_ready}, {31'd0, e1});
        if (e0 || e1) begin
          g = e1 ? 1 : 0;
          acc_q.push_back('{cyc: cyc + 1, g: g, we: wev[g], addr: ad[g], data: wd[g], be: bev[g]});
          last = e1;
          cnt  = 2;
        end else if (cnt > 0) begin
          cnt--;
        end
      end
    end
  end

  // Present one request and hold it until it is accepted, then scramble the fields.
  task automatic send(input int n, input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] b);
    bit done;
    done = 1'b0;
    v[n] = 1'b1; wev[n] = w; ad[n] = a; wd[n] = d; bev[n] = b;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if ((n == 0) ? m0_req_ready : m1_req_ready) done = 1'b1;
    end
    if (!done) begin
      errors++;
      $display("FAIL handshake_timeout m%0d got=no_ready expected=ready", n);
    end
    @(posedge clk);
    #1;
    v[n] = 1'b0;
    wd[n] = $urandom;
    ad[n] = 8'($urandom_range(0, 15));
  endtask

  task automatic rand_traffic(input int n, input int count);
    for (int k = 0; k < count; k++) begin
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      if ($urandom_range(0, 4) == 0) begin
        v[n] = 1'b1; wev[n] = 1'($urandom); ad[n] = 8'($urandom_range(0, 15));
        wd[n] = $urandom; bev[n] = 4'($urandom);
        @(posedge clk); #1;
        v[n] = 1'b0;
      end else begin
        send(n, 1'($urandom), 8'($urandom_range(0, 15)), $urandom, 4'($urandom));
      end
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; v = 2'b00; wev = 2'b00;
    for (int i = 0; i < 2; i++) begin ad[i] = 8'd0; wd[i] = 32'd0; bev[i] = 4'd0; end
    #1;
    chk("rst_rd_addr", {24'd0, rf_rd_addr}, 32'h0000_00FF);
    chk("rst_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_rsp", {30'd0, m1_rsp_valid, m0_rsp_valid}, 32'd0);
    chk("rst_rdata", m0_rsp_rdata | m1_rsp_rdata, 32'd0);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    // Directed: write followed by a read-back from m0, then a byte-lane write from m1.
    send(0, 1'b1, 8'h04, 32'hDEADBEEF, 4'hF);
    repeat (3) begin @(posedge clk); #1; end
    send(0, 1'b1, 8'h04, 32'h12345678, 4'hF);
    repeat (3) begin @(posedge clk); #1; end
    send(0, 1'b0, 8'h04, 32'h0, 4'h0);
    repeat (3) begin @(posedge clk); #1; end
    send(1, 1'b1, 8'h08, 32'hAABBCCDD, 4'b0010);
    repeat (3) begin @(posedge clk); #1; end

    // Both requesters continuously valid, four reads each.
    fork
      begin for (int k = 0; k < 4; k++) send(0, 1'b0, 8'(k), 32'h0, 4'h0); end
      begin for (int k = 0; k < 4; k++) send(1, 1'b0, 8'(k + 8), 32'h0, 4'h0); end
    join
    repeat (4) begin @(posedge clk); #1; end

    // Reset during the ACCESS cycle of an m1 write.
    send(1, 1'b1, 8'h05, 32'hCAFEF00D, 4'hF);
    #1;
    chk("pre_rst_wr_en", {31'd0, rf_wr_en}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("async_wr_en", {31'd0, rf_wr_en}, 32'd0);
    chk("async_rd_addr", {24'd0, rf_rd_addr}, 32'h0000_00FF);
    chk("async_rsp1", {31'd0, m1_rsp_valid}, 32'd0);
    @(posedge clk); #3;
    chk("rst_hold_rsp1", {31'd0, m1_rsp_valid}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    fork
      send(0, 1'b0, 8'h05, 32'h0, 4'h0);
      send(1, 1'b0, 8'h06, 32'h0, 4'h0);
    join
    repeat (4) begin @(posedge clk); #1; end

    // Long idle stretch, then an m1 pulse that falls while the arbiter is busy.
    repeat (100) begin @(posedge clk); #1; end
    send(0, 1'b0, 8'h04, 32'h0, 4'h0);
    v[1] = 1'b1; wev[1] = 1'b1; ad[1] = 8'h07; wd[1] = 32'h5555AAAA; bev[1] = 4'hF;
    @(posedge clk); #1;
    v[1] = 1'b0;
    repeat (6) begin @(posedge clk); #1; end

    // Random concurrent traffic.
    fork
      rand_traffic(0, 40);
      rand_traffic(1, 40);
    join
    repeat (6) begin @(posedge clk); #1; end
    chk("acc_q_empty", acc_q.size(), 32'd0);
    chk("rsp_q_empty", rsp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
